// File: rtl/multiport_register_file.sv
// multiport_register_file: NUM_READ combinational read ports, two prioritised
// write lanes (lane 1 wins on an address clash), and a per-register busy
// scoreboard (reserve sets, writeback clears, reserve beats writeback).
// Register 0 always reads as zero and is never busy.
// Optional: define MULTIPORT_RF_WRITE_BYPASS_EN to forward same-cycle write
// data (and the resulting busy state) to matching read ports.
module multiport_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_sel,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  output logic [NUM_READ-1:0]            read_busy,
  input  logic                           write0,
  input  logic [ADDR_WIDTH-1:0]          write_sel0,
  input  logic [DATA_WIDTH-1:0]          write_data0,
  input  logic                           write1,
  input  logic [ADDR_WIDTH-1:0]          write_sel1,
  input  logic [DATA_WIDTH-1:0]          write_data1,
  input  logic                           reserve,
  input  logic [ADDR_WIDTH-1:0]          reserve_sel,
  output logic                           write_collision
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic                  w0_do;
  logic                  w1_do;
  logic                  same_addr;
  logic                  rsv_do;

  // Qualify lane enables: writes to register 0 are dropped
  always_comb begin
    w0_do     = write0 && (write_sel0 != '0);
    w1_do     = write1 && (write_sel1 != '0);
    same_addr = w0_do && w1_do && (write_sel0 == write_sel1);
    rsv_do    = reserve && (reserve_sel != '0);
  end

  // Scoreboard next state: writebacks clear first, then a reserve sets, so a
  // same-cycle reserve of the retiring register keeps it busy
  always_comb begin
    busy_next = busy;
    if (w0_do) busy_next[write_sel0] = 1'b0;
    if (w1_do) busy_next[write_sel1] = 1'b0;
    if (rsv_do) busy_next[reserve_sel] = 1'b1;
  end

  // Storage, scoreboard and collision flag update with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy            <= '0;
      write_collision <= 1'b0;
    end else begin
      if (w0_do && !same_addr) regs[write_sel0] <= write_data0;
      if (w1_do) regs[write_sel1] <= write_data1;
      busy            <= busy_next;
      write_collision <= same_addr;
    end
  end

  // Combinational read ports, register 0 forced to zero / not busy
  always_comb begin
    read_data = '0;
    read_busy = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      logic [ADDR_WIDTH-1:0] sel;
      sel = read_sel[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (sel != '0) begin
        read_data[i*DATA_WIDTH +: DATA_WIDTH] = regs[sel];
        read_busy[i]                          = busy[sel];
`ifdef MULTIPORT_RF_WRITE_BYPASS_EN
        // Forwarded value reflects the post-edge state: data from the
        // winning lane, busy only if a reserve lands on it this cycle
        if (w1_do && (write_sel1 == sel)) begin
          read_data[i*DATA_WIDTH +: DATA_WIDTH] = write_data1;
          read_busy[i]                          = rsv_do && (reserve_sel == sel);
        end else if (w0_do && (write_sel0 == sel)) begin
          read_data[i*DATA_WIDTH +: DATA_WIDTH] = write_data0;
          read_busy[i]                          = rsv_do && (reserve_sel == sel);
        end
`endif
      end
    end
  end

endmodule
